// File: rtl/asi_pkg.sv
// Shared types for the ASI user-port arbiter.
// Arbiter FSM states, owner tags and the arbitration mode constants.
package asi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WOWN,
        ROWN
    } arb_st_e;

    typedef enum logic {
        OWN_W,
        OWN_R
    } owner_e;

    localparam int ARB_WPRI = 0;
    localparam int ARB_RPRI = 1;
    localparam int ARB_RR   = 2;

endpackage

// File: rtl/asi_arb_if.sv
// User-side bundle between asi_w/asi_r and the arbiter.
// master: write/read paths (requests, beats); slave: arbiter (grants).
interface asi_arb_if #(
    parameter int AXI_AW     = 40,
    parameter int AXI_DW     = 128,
    parameter int AXI_WSTRBW = AXI_DW / 8
) ();

    logic                  usr_wrequest;
    logic                  usr_wgrant;
    logic [AXI_AW-1:0]     usr_waddr;
    logic [AXI_DW-1:0]     usr_wdata;
    logic [AXI_WSTRBW-1:0] usr_wstrb;
    logic                  usr_we;
    logic                  usr_wlast;

    logic                  usr_rrequest;
    logic                  usr_rgrant;
    logic [AXI_AW-1:0]     usr_raddr;
    logic                  usr_re;
    logic                  usr_rlast;

    modport master (
        output usr_wrequest, usr_waddr, usr_wdata, usr_wstrb,
        output usr_we, usr_wlast,
        output usr_rrequest, usr_raddr, usr_re, usr_rlast,
        input  usr_wgrant, usr_rgrant
    );

    modport slave (
        input  usr_wrequest, usr_waddr, usr_wdata, usr_wstrb,
        input  usr_we, usr_wlast,
        input  usr_rrequest, usr_raddr, usr_re, usr_rlast,
        output usr_wgrant, usr_rgrant
    );

endinterface

// File: rtl/asi_arb.sv
// Burst-granular arbiter for the single user memory port (usr_clk domain).
// Ports: clk, rst_n (async low); usr (asi_arb_if.slave: requests, beats,
// grants); mem_addr/mem_wdata/mem_be/mem_we/mem_re (muxed memory port);
// arb_busy (grant active); err_ungranted (sticky enable-without-grant).
module asi_arb
    import asi_pkg::*;
#(
    parameter int AXI_AW     = 40,
    parameter int AXI_DW     = 128,
    parameter int AXI_WSTRBW = AXI_DW / 8,
    parameter int ARB_MODE   = ARB_WPRI,
    parameter int STARVE_MAX = 4,
    parameter int STARVE_W   = $clog2(STARVE_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    asi_arb_if.slave              usr,
    output logic [AXI_AW-1:0]     mem_addr,
    output logic [AXI_DW-1:0]     mem_wdata,
    output logic [AXI_WSTRBW-1:0] mem_be,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  arb_busy,
    output logic                  err_ungranted
);

    // STARVE_MAX=0 gives a zero-width counter; keep one bit that never moves.
    localparam int CW = (STARVE_W > 0) ? STARVE_W : 1;
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
    localparam arb_st_e HI_ST = (ARB_MODE == ARB_RPRI) ? ROWN : WOWN;
    localparam arb_st_e LO_ST = (ARB_MODE == ARB_RPRI) ? WOWN : ROWN;

    arb_st_e       state;
    arb_st_e       state_d;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_d;
    owner_e        last_owner;
    owner_e        last_d;
    logic          err_d;
    logic          dec;
    logic          wgrant;
    logic          rgrant;

    function automatic arb_st_e pick(
        input logic          wreq,
        input logic          rreq,
        input logic [CW-1:0] cnt,
        input owner_e        last
    );
        arb_st_e win;
        win = IDLE;
        if (wreq && !rreq) begin
            win = WOWN;
        end else if (rreq && !wreq) begin
            win = ROWN;
        end else if (wreq && rreq) begin
            if (ARB_MODE == ARB_RR) begin
                win = (last == OWN_W) ? ROWN : WOWN;
            end else if (STARVE_MAX != 0 && cnt == SMAX) begin
                win = LO_ST;
            end else begin
                win = HI_ST;
            end
        end
        return win;
    endfunction

    // Grants come straight from the state flops: requests may depend on them.
    assign wgrant         = (state == WOWN);
    assign rgrant         = (state == ROWN);
    assign usr.usr_wgrant = wgrant;
    assign usr.usr_rgrant = rgrant;
    assign arb_busy       = (state != IDLE);

    always_comb begin
        dec      = 1'b0;
        state_d  = state;
        starve_d = starve_cnt;
        last_d   = last_owner;

        // Owner's last beat is a decision point, so the handover has no bubble.
        unique case (state)
            WOWN:    dec = usr.usr_we & usr.usr_wlast;
            ROWN:    dec = usr.usr_re & usr.usr_rlast;
            default: dec = 1'b1;
        endcase

        if (dec) begin
            state_d = pick(usr.usr_wrequest, usr.usr_rrequest,
                           starve_cnt, last_owner);
            if (ARB_MODE != ARB_RR) begin
                if (state_d == LO_ST) begin
                    starve_d = '0;
                end else if (state_d == HI_ST && usr.usr_wrequest &&
                             usr.usr_rrequest && starve_cnt != SMAX) begin
                    starve_d = starve_cnt + CW'(1);
                end
            end
            if (state_d != IDLE) begin
                last_d = (state_d == WOWN) ? OWN_W : OWN_R;
            end
        end
    end

    assign err_d = err_ungranted
                 | (usr.usr_we & ~wgrant)
                 | (usr.usr_re & ~rgrant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            last_owner    <= OWN_R;
            err_ungranted <= 1'b0;
        end else begin
            state         <= state_d;
            starve_cnt    <= starve_d;
            last_owner    <= last_d;
            err_ungranted <= err_d;
        end
    end

    assign mem_we    = usr.usr_we & wgrant;
    assign mem_re    = usr.usr_re & rgrant;
    assign mem_be    = mem_we ? usr.usr_wstrb : '0;
    assign mem_wdata = wgrant ? usr.usr_wdata : '0;

    always_comb begin
        mem_addr = '0;
        unique case (1'b1)
            wgrant:  mem_addr = usr.usr_waddr;
            rgrant:  mem_addr = usr.usr_raddr;
            default: mem_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_asi_arb.sv
// Self-checking bench for asi_arb: three instances (write-priority with
// STARVE_MAX=2, read-priority with starvation off, round-robin).
module tb_asi_arb;
    import asi_pkg::*;

    localparam int AW = 40;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wreq, rreq, we, wlast, re, rlast;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;

    logic          o_wg[3], o_rg[3], o_we[3], o_re[3], o_busy[3], o_err[3];
    logic [AW-1:0] o_addr[3];
    logic [DW-1:0] o_wdata[3];
    logic [SW-1:0] o_be[3];

    for (genvar g = 0; g < 3; g++) begin : gd
        asi_arb_if #(.AXI_AW(AW), .AXI_DW(DW)) bus ();
        assign bus.usr_wrequest = wreq;
        assign bus.usr_waddr    = waddr;
        assign bus.usr_wdata    = wdata;
        assign bus.usr_wstrb    = wstrb;
        assign bus.usr_we       = we;
        assign bus.usr_wlast    = wlast;
        assign bus.usr_rrequest = rreq;
        assign bus.usr_raddr    = raddr;
        assign bus.usr_re       = re;
        assign bus.usr_rlast    = rlast;
        assign o_wg[g]          = bus.usr_wgrant;
        assign o_rg[g]          = bus.usr_rgrant;
        asi_arb #(
            .AXI_AW(AW), .AXI_DW(DW), .ARB_MODE(g),
            .STARVE_MAX(g == 0 ? 2 : (g == 1 ? 0 : 4))
        ) dut (
            .clk(clk), .rst_n(rst_n), .usr(bus),
            .mem_addr(o_addr[g]), .mem_wdata(o_wdata[g]),
            .mem_be(o_be[g]), .mem_we(o_we[g]), .mem_re(o_re[g]),
            .arb_busy(o_busy[g]), .err_ungranted(o_err[g])
        );
    end

    int dsel, mode, smax;
    int m_own, m_cnt, m_last;   // owner: 0 none, 1 write, 2 read
    bit m_err;
    int ntests = 0;
    int nfail = 0;
    int nwe;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_cnt = 0; m_last = 2; m_err = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; checks at negedge, advances model.
    task automatic tick();
        bit ew, er, dec;
        int win, hi, lo, nown, ncnt, nlast;
        bit nerr;
        #4;
        ew = (m_own == 1);
        er = (m_own == 2);
        chk("wgrant", o_wg[dsel], ew);
        chk("rgrant", o_rg[dsel], er);
        chk("mem_we", o_we[dsel], we & ew);
        chk("mem_re", o_re[dsel], re & er);
        chk("mem_addr", o_addr[dsel], ew ? waddr : (er ? raddr : '0));
        chk("mem_wdata", o_wdata[dsel], ew ? wdata : '0);
        chk("mem_be", o_be[dsel], (we & ew) ? wstrb : '0);
        chk("busy", o_busy[dsel], m_own != 0);
        chk("err", o_err[dsel], m_err);
        if (o_we[dsel] === 1'b1) nwe++;
        nerr = m_err | (we & !ew) | (re & !er);
        dec = (m_own == 0) || (ew && we && wlast) || (er && re && rlast);
        nown = m_own; ncnt = m_cnt; nlast = m_last;
        if (dec) begin
            win = 0;
            hi = (mode == 1) ? 2 : 1;
            lo = 3 - hi;
            if (wreq && !rreq) win = 1;
            else if (rreq && !wreq) win = 2;
            else if (wreq && rreq) begin
                if (mode == 2) win = (m_last == 1) ? 2 : 1;
                else begin
                    win = (smax != 0 && m_cnt == smax) ? lo : hi;
                    if (win == hi) ncnt = (m_cnt < smax) ? m_cnt + 1 : smax;
                end
            end
            if (mode != 2 && win == lo) ncnt = 0;
            nown = win;
            if (win != 0) nlast = win;
        end
        @(posedge clk);
        #1;
        m_own = nown; m_cnt = ncnt; m_last = nlast; m_err = nerr;
    endtask

    task automatic do_reset(input int sel);
        dsel = sel; mode = sel;
        smax = (sel == 0) ? 2 : ((sel == 1) ? 0 : 4);
        wreq = 0; rreq = 0; we = 0; wlast = 0; re = 0; rlast = 0;
        waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic beat(input int side, input bit last);
        waddr = {8'($urandom), 32'($urandom)};
        raddr = {8'($urandom), 32'($urandom)};
        wdata = {$urandom, $urandom, $urandom, $urandom};
        wstrb = 16'($urandom);
        if (side == 2) begin re = 1; rlast = last; end
        else begin we = 1; wlast = last; end
        tick();
        we = 0; wlast = 0; re = 0; rlast = 0;
    endtask

    task automatic burst(input int side, input int n);
        for (int i = 0; i < n; i++) beat(side, i == n - 1);
    endtask

    function automatic int owner();
        return o_wg[dsel] ? 1 : (o_rg[dsel] ? 2 : 0);
    endfunction

    int exp3[6] = '{1, 1, 2, 1, 1, 2};
    int exp4[6] = '{1, 2, 1, 2, 1, 2};

    initial begin
        int own;

        // Reset state and a lone 4-beat write burst.
        do_reset(0);
        #1;
        chk("rst_wg", o_wg[0], 0);
        chk("rst_rg", o_rg[0], 0);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_err", o_err[0], 0);
        chk("rst_addr", o_addr[0], 0);
        chk("rst_be", o_be[0], 0);
        wreq = 1;
        tick();
        chk("t1_wg", o_wg[0], 1);
        wreq = 0;
        nwe = 0;
        burst(1, 4);
        chk("t1_beats", nwe, 4);
        chk("t1_idle_wg", o_wg[0], 0);
        tick();

        // Both from idle: write first, read right after wlast.
        do_reset(0);
        wreq = 1; rreq = 1;
        tick();
        chk("t2_wg", o_wg[0], 1);
        chk("t2_rg0", o_rg[0], 0);
        wreq = 0;
        burst(1, 4);
        chk("t2_rg", o_rg[0], 1);
        rreq = 0;
        burst(2, 2);
        chk("t2_idle", o_busy[0], 0);
        tick();

        // Starvation limit 2 under constant contention.
        do_reset(0);
        wreq = 1; rreq = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            own = owner();
            chk($sformatf("t3_ord%0d", k), own, exp3[k]);
            burst(own == 0 ? 1 : own, 2);
        end
        wreq = 0; rreq = 0;
        own = owner();
        chk("t3_tail", own, 1);
        burst(own == 0 ? 1 : own, 1);
        tick();

        // Round-robin with single-beat bursts.
        do_reset(2);
        wreq = 1; rreq = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            own = owner();
            chk($sformatf("t4_ord%0d", k), own, exp4[k]);
            burst(own == 0 ? 1 : own, 1);
        end
        wreq = 0; rreq = 0;
        own = owner();
        burst(own == 0 ? 1 : own, 1);
        tick();

        // Read enable during a write burst.
        do_reset(0);
        wreq = 1;
        tick();
        wreq = 0;
        re = 1;
        #2;
        chk("t5_mem_re", o_re[0], 0);
        tick();
        re = 0;
        chk("t5_err", o_err[0], 1);
        burst(1, 3);
        chk("t5_err_hold", o_err[0], 1);
        do_reset(0);
        #1;
        chk("t5_err_clr", o_err[0], 0);

        // Reset in the middle of an 8-beat write.
        do_reset(0);
        wreq = 1;
        tick();
        wreq = 0;
        for (int i = 0; i < 3; i++) beat(1, 0);
        we = 1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_wg_async", o_wg[0], 0);
        chk("t6_busy_async", o_busy[0], 0);
        model_reset();
        we = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wreq = 1;
        #1;
        chk("t6_wg_rel", o_wg[0], 0);
        tick();
        chk("t6_wg_again", o_wg[0], 1);
        wreq = 0;
        burst(1, 1);
        tick();

        // Random traffic against the model on each instance.
        for (int s = 0; s < 3; s++) begin
            do_reset(s);
            repeat (300) begin
                wreq  = ($urandom_range(0, 3) != 0);
                rreq  = ($urandom_range(0, 3) != 0);
                we    = (m_own == 1) ? ($urandom_range(0, 3) != 0)
                                     : ($urandom_range(0, 60) == 0);
                re    = (m_own == 2) ? ($urandom_range(0, 3) != 0)
                                     : ($urandom_range(0, 60) == 0);
                wlast = ($urandom_range(0, 2) == 0);
                rlast = ($urandom_range(0, 2) == 0);
                waddr = {8'($urandom), 32'($urandom)};
                raddr = {8'($urandom), 32'($urandom)};
                wdata = {$urandom, $urandom, $urandom, $urandom};
                wstrb = 16'($urandom);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
